// File: rtl/break_arbiter.sv
// ---------------------------------------------------------------------------
// break_arbiter
//
// Data-break (DMA) arbiter and sequencer sitting between the PDP-8/e state
// machine and memory. Up to NDEV devices post break requests; one winner is
// picked, a break slot is requested from the CPU, a single 12-bit memory
// cycle is run on the winner's 15-bit address and the winner is acknowledged.
// For the whole break cycle this block owns the memory port.
//
// Parameters
//   NDEV       number of requesting devices, index 0 = highest priority
//   RR         0 = fixed priority, 1 = round-robin starting after last winner
//   MEM_LAT    clocks the memory strobe is held (read data valid at the end)
//   MAX_BURST  consecutive break cycles before a forced one-clock CPU release
//
// Ports
//   clk, reset      system clock, asynchronous active-high reset
//   clear           front-panel CLEAR, synchronous abort of pending requests
//   req             per-device break request (level)
//   dev_wr          per-device direction, 1 = device->memory
//   dev_addr        per-device 15-bit address, device i at [15*i +: 15]
//   dev_wdata       per-device 12-bit write data, device i at [12*i +: 12]
//   break_ok        state machine grants the break slot
//   mem_rdata       memory read data
//   break_req       break request to the state machine
//   break_in_prog   high from ADDR through DONE
//   grant           one-hot winner, stable from ADDR to DONE
//   ack             one-clock pulse to the winner in DONE
//   dev_rdata       read data, valid while ack is high
//   mem_addr, mem_wdata, mem_rd, mem_we   memory port
//
// Device handshake: a device raises req[i] (with dev_wr/addr/wdata stable)
// and holds it until it sees ack[i]; ack is a single-clock pulse and the
// device drops req[i] on the following clock. The arbiter ignores req[i] of
// the just-acknowledged device in DONE and in the clock after, so a device
// that drops one clock late is never served twice.
// ---------------------------------------------------------------------------
module break_arbiter #(
    parameter int NDEV      = 2,
    parameter int RR        = 0,
    parameter int MEM_LAT   = 2,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic [NDEV-1:0]      req,
    input  logic [NDEV-1:0]      dev_wr,
    input  logic [NDEV*15-1:0]   dev_addr,
    input  logic [NDEV*12-1:0]   dev_wdata,
    input  logic                 break_ok,
    input  logic [11:0]          mem_rdata,
    output logic                 break_req,
    output logic                 break_in_prog,
    output logic [NDEV-1:0]      grant,
    output logic [NDEV-1:0]      ack,
    output logic [11:0]          dev_rdata,
    output logic [14:0]          mem_addr,
    output logic [11:0]          mem_wdata,
    output logic                 mem_rd,
    output logic                 mem_we
);

    localparam int IDXW = (NDEV > 1) ? $clog2(NDEV) : 1;
    localparam int LATW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int BW   = $clog2(MAX_BURST + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_ADDR = 3'd2,
        S_XFER = 3'd3,
        S_DONE = 3'd4,
        S_GAP  = 3'd5
    } state_t;

    state_t state;
    state_t state_next;

    // Latched transaction (valid from ADDR to DONE)
    logic [IDXW-1:0] win_idx;
    logic [NDEV-1:0] win_oh;
    logic [14:0]     addr_q;
    logic [11:0]     wdata_q;
    logic            dir_q;
    logic [11:0]     rdata_q;

    logic [LATW-1:0] lat_cnt;
    logic [BW-1:0]   burst_cnt;
    logic [BW-1:0]   burst_inc;
    logic [IDXW-1:0] rr_ptr;
    logic            clr_seen;
    logic            mask_q;
    logic            take;
    logic            lat_last;

    // Per-device fields unpacked for indexed selection
    logic [14:0] addr_arr  [NDEV];
    logic [11:0] wdata_arr [NDEV];

    for (genvar g = 0; g < NDEV; g++) begin : g_unpack
        assign addr_arr[g]  = dev_addr[15*g +: 15];
        assign wdata_arr[g] = dev_wdata[12*g +: 12];
    end

    // -----------------------------------------------------------------------
    // Arbitration
    // -----------------------------------------------------------------------
    logic [NDEV-1:0] mask;
    logic [NDEV-1:0] arb_req;
    logic [IDXW-1:0] ptr_sel;
    logic [IDXW-1:0] ptr_eff;
    logic [IDXW-1:0] sel_idx;
    logic [NDEV-1:0] sel_oh;
    logic            sel_found;

    always_comb begin
        mask = '0;
        if (state == S_DONE || mask_q) begin
            mask = win_oh;
        end
    end

    assign arb_req = req & ~mask;

    // In DONE the new winner is chosen relative to the device just served,
    // before rr_ptr has been updated.
    assign ptr_sel = (state == S_DONE) ? win_idx : rr_ptr;

    // Fixed priority is round-robin with the pointer parked on the last
    // index: "first set index after NDEV-1" is the lowest set index.
    assign ptr_eff = (RR != 0) ? ptr_sel : IDXW'(NDEV - 1);

    // Two passes, highest index first so the lowest index of a pass wins.
    // The second pass (indices after the pointer) overrides the wrapped one.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = NDEV - 1; i >= 0; i--) begin
            if (arb_req[i] && (IDXW'(i) <= ptr_eff)) begin
                sel_found = 1'b1;
                sel_idx   = IDXW'(i);
            end
        end
        for (int i = NDEV - 1; i >= 0; i--) begin
            if (arb_req[i] && (IDXW'(i) > ptr_eff)) begin
                sel_found = 1'b1;
                sel_idx   = IDXW'(i);
            end
        end
    end

    always_comb begin
        sel_oh = '0;
        for (int i = 0; i < NDEV; i++) begin
            sel_oh[i] = sel_found && (sel_idx == IDXW'(i));
        end
    end

    // -----------------------------------------------------------------------
    // Sequencer FSM
    // -----------------------------------------------------------------------
    assign lat_last  = (lat_cnt == LATW'(MEM_LAT - 1));
    assign burst_inc = burst_cnt + BW'(1);

    always_comb begin
        state_next = state;
        take       = 1'b0;
        case (state)
            S_IDLE: begin
                if (|arb_req && !clear) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (clear || !sel_found) begin
                    state_next = S_IDLE;
                end else if (break_ok) begin
                    state_next = S_ADDR;
                    take       = 1'b1;
                end
            end
            S_ADDR: begin
                state_next = S_XFER;
            end
            S_XFER: begin
                // Requests and clear are ignored here; the cycle always runs.
                if (lat_last) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (clr_seen || clear) begin
                    state_next = S_IDLE;
                end else if (burst_inc == BW'(MAX_BURST)) begin
                    state_next = S_GAP;
                end else if (sel_found && break_ok) begin
                    state_next = S_ADDR;
                    take       = 1'b1;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_GAP: begin
                // The one-clock release is this state alone; pending requests
                // go straight back to WAIT rather than idling another clock.
                if (|arb_req && !clear) begin
                    state_next = S_WAIT;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            win_idx   <= '0;
            win_oh    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            dir_q     <= 1'b0;
            rdata_q   <= '0;
            lat_cnt   <= '0;
            burst_cnt <= '0;
            rr_ptr    <= '0;
            clr_seen  <= 1'b0;
            mask_q    <= 1'b0;
        end else begin
            state  <= state_next;
            mask_q <= (state == S_DONE);

            if (take) begin
                win_idx <= sel_idx;
                win_oh  <= sel_oh;
                addr_q  <= addr_arr[sel_idx];
                wdata_q <= wdata_arr[sel_idx];
                dir_q   <= dev_wr[sel_idx];
            end

            if (state == S_XFER && !lat_last) begin
                lat_cnt <= lat_cnt + LATW'(1);
            end else begin
                lat_cnt <= '0;
            end

            // Read data sampled on the edge that ends the last strobe clock
            if (state == S_XFER && lat_last && !dir_q) begin
                rdata_q <= mem_rdata;
            end

            // Remember a clear that arrives while the cycle is committed
            if (state == S_ADDR || state == S_XFER) begin
                clr_seen <= clr_seen | clear;
            end else begin
                clr_seen <= 1'b0;
            end

            // Burst count survives only a direct DONE->ADDR chain
            if (state == S_DONE) begin
                burst_cnt <= (state_next == S_ADDR) ? burst_inc : '0;
                rr_ptr    <= win_idx;
            end else if (state == S_IDLE || state == S_GAP) begin
                burst_cnt <= '0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs, decoded from registered state so reset clears them at once
    // -----------------------------------------------------------------------
    logic in_cycle;

    assign in_cycle      = (state == S_ADDR) || (state == S_XFER) || (state == S_DONE);
    assign break_req     = (state == S_WAIT) || in_cycle;
    assign break_in_prog = in_cycle;
    assign grant         = in_cycle ? win_oh : '0;
    assign ack           = (state == S_DONE) ? win_oh : '0;
    assign dev_rdata     = (state == S_DONE && !dir_q) ? rdata_q : '0;
    assign mem_addr      = (state == S_ADDR || state == S_XFER) ? addr_q : '0;
    assign mem_wdata     = (state == S_XFER && dir_q) ? wdata_q : '0;
    assign mem_rd        = (state == S_XFER) && !dir_q;
    assign mem_we        = (state == S_XFER) && dir_q;

    a_strobe_excl : assert property (@(posedge clk) disable iff (reset) !(mem_rd && mem_we));
    a_grant_oh    : assert property (@(posedge clk) disable iff (reset) $onehot0(grant));
    a_ack_oh      : assert property (@(posedge clk) disable iff (reset) $onehot0(ack));

endmodule

// File: tb/tb_break_arbiter.sv
// ---------------------------------------------------------------------------
// tb_break_arbiter
//
// Bench for break_arbiter. u_fix is a fixed-priority instance with a bench
// memory; u_rr is a round-robin instance whose memory returns a fixed
// function of the address. Expected acks {one-hot, read data} are queued
// when a request is driven and popped when the DUT pulses ack.
// ---------------------------------------------------------------------------
module tb_break_arbiter;

    localparam int NDEV      = 2;
    localparam int MEM_LAT   = 2;
    localparam int MAX_BURST = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- fixed-priority DUT ----------------
    logic        clear;
    logic        break_ok;
    logic [1:0]  req;
    logic [1:0]  dev_wr;
    logic [29:0] dev_addr;
    logic [23:0] dev_wdata;
    logic [11:0] mem_rdata;
    logic        break_req;
    logic        break_in_prog;
    logic [1:0]  grant;
    logic [1:0]  ack;
    logic [11:0] dev_rdata;
    logic [14:0] mem_addr;
    logic [11:0] mem_wdata;
    logic        mem_rd;
    logic        mem_we;

    logic [11:0] mem     [0:32767];
    logic [11:0] ref_mem [0:32767];

    assign mem_rdata = mem[mem_addr];

    break_arbiter #(.NDEV(NDEV), .RR(0), .MEM_LAT(MEM_LAT), .MAX_BURST(MAX_BURST)) u_fix (
        .clk           (clk),
        .reset         (rst),
        .clear         (clear),
        .req           (req),
        .dev_wr        (dev_wr),
        .dev_addr      (dev_addr),
        .dev_wdata     (dev_wdata),
        .break_ok      (break_ok),
        .mem_rdata     (mem_rdata),
        .break_req     (break_req),
        .break_in_prog (break_in_prog),
        .grant         (grant),
        .ack           (ack),
        .dev_rdata     (dev_rdata),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rd        (mem_rd),
        .mem_we        (mem_we)
    );

    // ---------------- round-robin DUT ----------------
    logic [1:0]  r_req;
    logic        r_break_ok;
    logic [11:0] r_mem_rdata;
    logic        r_break_req;
    logic        r_break_in_prog;
    logic [1:0]  r_grant;
    logic [1:0]  r_ack;
    logic [11:0] r_dev_rdata;
    logic [14:0] r_mem_addr;
    logic [11:0] r_mem_wdata;
    logic        r_mem_rd;
    logic        r_mem_we;

    localparam logic [14:0] R_A0 = 15'o01000;
    localparam logic [14:0] R_A1 = 15'o02000;

    assign r_mem_rdata = r_mem_addr[11:0] ^ 12'o5252;

    break_arbiter #(.NDEV(NDEV), .RR(1), .MEM_LAT(MEM_LAT), .MAX_BURST(MAX_BURST)) u_rr (
        .clk           (clk),
        .reset         (rst),
        .clear         (1'b0),
        .req           (r_req),
        .dev_wr        (2'b00),
        .dev_addr      ({R_A1, R_A0}),
        .dev_wdata     (24'h0),
        .break_ok      (r_break_ok),
        .mem_rdata     (r_mem_rdata),
        .break_req     (r_break_req),
        .break_in_prog (r_break_in_prog),
        .grant         (r_grant),
        .ack           (r_ack),
        .dev_rdata     (r_dev_rdata),
        .mem_addr      (r_mem_addr),
        .mem_wdata     (r_mem_wdata),
        .mem_rd        (r_mem_rd),
        .mem_we        (r_mem_we)
    );

    // ---------------- scoreboard state ----------------
    logic [13:0] exp_q[$];
    int    checks   = 0;
    int    failures = 0;
    int    we_clks, rd_clks, ack_seen, brk_rises;
    logic  brk_prev;
    int    r_low;
    logic  r_started;
    string tag = "reset";

    function automatic logic [11:0] rr_data(input logic [14:0] a);
        return a[11:0] ^ 12'o5252;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s [%s] actual=%0h required=%0h", name, tag, act, exp);
        end
    endtask

    task automatic clr_counts();
        we_clks   = 0;
        rd_clks   = 0;
        ack_seen  = 0;
        brk_rises = 0;
        brk_prev  = break_req;
    endtask

    // One clock of the fixed-priority DUT: memory model, ack scoreboard and
    // device model (req dropped once ack has been seen).
    task automatic step();
        logic [13:0] e;
        if (mem_we) begin
            mem[mem_addr] = mem_wdata;
            we_clks++;
        end
        if (mem_rd) rd_clks++;
        @(posedge clk);
        #1;
        if (break_req && !brk_prev) brk_rises++;
        brk_prev = break_req;
        if (ack != 2'b00) begin
            ack_seen++;
            if (exp_q.size() == 0) begin
                check("ack_unexpected", {ack, dev_rdata}, 64'h0);
            end else begin
                e = exp_q.pop_front();
                check("ack_dev", ack, e[13:12]);
                check("ack_rdata", dev_rdata, e[11:0]);
            end
            req = req & ~ack;
        end
    endtask

    task automatic run_txn(input int budget);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while ((exp_q.size() != 0 || break_req) && n < budget);
        check("txn_complete", {exp_q.size() == 0, !break_req}, 2'b11);
        exp_q.delete();
        req = 2'b00;
    endtask

    // One clock of the round-robin DUT; hold keeps requests up after ack.
    task automatic rr_step(input logic hold);
        logic [13:0] e;
        @(posedge clk);
        #1;
        if (r_break_req) r_started = 1'b1;
        else if (r_started) r_low++;
        if (r_ack != 2'b00) begin
            if (exp_q.size() == 0) begin
                check("rr_ack_unexpected", r_ack, 2'b00);
            end else begin
                e = exp_q.pop_front();
                check("rr_winner", r_ack, e[13:12]);
                check("rr_rdata", r_dev_rdata, e[11:0]);
            end
            if (!hold) r_req = r_req & ~r_ack;
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic [1:0]  req;
        logic [1:0]  wr;
        logic [14:0] a0;
        logic [14:0] a1;
        logic [11:0] d0;
        logic [11:0] d1;
        logic [1:0]  first;   // expected first winner (one-hot)
    } vec_t;

    vec_t vecs [6];

    // ---------------- main sequence ----------------
    initial begin
        int n;
        rst        = 1'b1;
        clear      = 1'b0;
        break_ok   = 1'b0;
        req        = 2'b00;
        dev_wr     = 2'b00;
        dev_addr   = '0;
        dev_wdata  = '0;
        r_req      = 2'b00;
        r_break_ok = 1'b0;
        for (int a = 0; a < 32768; a++) begin
            mem[a]     = 12'(a ^ (a >> 3) ^ 32'h5A5);
            ref_mem[a] = 12'(a ^ (a >> 3) ^ 32'h5A5);
        end

        vecs[0] = '{req:2'b01, wr:2'b01, a0:15'o07770, a1:15'o00000, d0:12'o1234, d1:12'o0000, first:2'b01};
        vecs[1] = '{req:2'b11, wr:2'b00, a0:15'o00100, a1:15'o77777, d0:12'o0000, d1:12'o0000, first:2'b01};
        vecs[2] = '{req:2'b10, wr:2'b10, a0:15'o00000, a1:15'o00000, d0:12'o0000, d1:12'o7777, first:2'b10};
        vecs[3] = '{req:2'b11, wr:2'b01, a0:15'o12345, a1:15'o54321, d0:12'o0001, d1:12'o0000, first:2'b01};
        vecs[4] = '{req:2'b11, wr:2'b11, a0:15'o40000, a1:15'o40000, d0:12'o1111, d1:12'o2222, first:2'b01};
        vecs[5] = '{req:2'b11, wr:2'b10, a0:15'o40000, a1:15'o00007, d0:12'o0000, d1:12'o6543, first:2'b01};

        // ---- reset ----
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              {break_req, break_in_prog, grant, ack, dev_rdata, mem_addr, mem_wdata, mem_rd, mem_we},
              64'h0);
        check("reset_rr_outputs", {r_break_req, r_grant, r_ack, r_mem_rd, r_mem_we}, 64'h0);
        rst = 1'b0;
        break_ok = 1'b1;
        step();
        check("idle_no_req", {break_req, grant}, 64'h0);

        // ---- table-driven single and back-to-back cycles ----
        for (int v = 0; v < 6; v++) begin
            vec_t t;
            int nw;
            int nr;
            t = vecs[v];
            $sformat(tag, "vec%0d", v);
            dev_wr    = t.wr;
            dev_addr  = {t.a1, t.a0};
            dev_wdata = {t.d1, t.d0};
            nw = 0;
            nr = 0;
            for (int k = 0; k < 2; k++) begin
                logic [1:0]  oh;
                logic [14:0] a;
                logic [11:0] d;
                logic        w;
                oh = (k == 0) ? t.first : (t.req & ~t.first);
                if (oh != 2'b00) begin
                    a = oh[1] ? t.a1 : t.a0;
                    d = oh[1] ? t.d1 : t.d0;
                    w = oh[1] ? t.wr[1] : t.wr[0];
                    if (w) begin
                        exp_q.push_back({oh, 12'h000});
                        ref_mem[a] = d;
                        nw++;
                    end else begin
                        exp_q.push_back({oh, ref_mem[a]});
                        nr++;
                    end
                end
            end
            clr_counts();
            req = t.req;
            run_txn(60);
            check("we_clks", we_clks, MEM_LAT * nw);
            check("rd_clks", rd_clks, MEM_LAT * nr);
            check("break_req_rises", brk_rises, 1);
            if (t.req[0] && t.wr[0]) check("mem_dev0", mem[t.a0], ref_mem[t.a0]);
            if (t.req[1] && t.wr[1]) check("mem_dev1", mem[t.a1], ref_mem[t.a1]);
            step();
        end

        // ---- break_ok withheld, then request abandoned ----
        tag = "no_slot";
        dev_wr   = 2'b00;
        dev_addr = {15'o00002, 15'o00001};
        break_ok = 1'b0;
        clr_counts();
        req = 2'b01;
        repeat (10) step();
        check("wait_break_req", break_req, 1'b1);
        check("wait_no_grant", {grant, break_in_prog}, 3'b000);
        req = 2'b00;
        step();
        step();
        check("abandon_idle", {break_req, break_in_prog}, 2'b00);
        check("abandon_no_strobe", rd_clks + we_clks, 0);
        check("abandon_no_ack", ack_seen, 0);
        break_ok = 1'b1;
        step();

        // ---- clear during a write, dev1 pending ----
        tag = "clear";
        dev_wr    = 2'b01;
        dev_addr  = {15'o60606, 15'o17170};
        dev_wdata = {12'o0000, 12'o0707};
        exp_q.push_back({2'b01, 12'h000});
        ref_mem[15'o17170] = 12'o0707;
        clr_counts();
        req = 2'b11;
        n = 0;
        while (!mem_we && n < 20) begin
            step();
            n++;
        end
        check("clr_reach_xfer", mem_we, 1'b1);
        clear = 1'b1;
        n = 0;
        while (ack_seen == 0 && n < 20) begin
            step();
            n++;
        end
        check("clr_ack_count", ack_seen, 1);
        step();
        check("clr_to_idle", {break_req, grant, break_in_prog}, 64'h0);
        check("clr_write_len", we_clks, MEM_LAT);
        check("clr_write_data", mem[15'o17170], ref_mem[15'o17170]);
        repeat (3) step();
        check("clr_holds_dev1", {break_req, mem_rd}, 2'b00);
        check("clr_no_extra_ack", ack_seen, 1);
        clear = 1'b0;
        exp_q.push_back({2'b10, ref_mem[15'o60606]});
        clr_counts();
        run_txn(40);
        check("clr_dev1_rd_clks", rd_clks, MEM_LAT);
        step();

        // ---- reset in the middle of a read ----
        tag = "reset_mid";
        dev_wr   = 2'b00;
        dev_addr = {15'o00000, 15'o25252};
        clr_counts();
        req = 2'b01;
        n = 0;
        while (!mem_rd && n < 20) begin
            step();
            n++;
        end
        check("rst_reach_xfer", mem_rd, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_outputs", {mem_rd, mem_we, break_req, grant, ack, break_in_prog}, 64'h0);
        req = 2'b00;
        step();
        step();
        rst = 1'b0;
        check("rst_no_ack", ack_seen, 0);
        dev_wr    = 2'b10;
        dev_addr  = {15'o33333, 15'o00000};
        dev_wdata = {12'o4321, 12'o0000};
        exp_q.push_back({2'b10, 12'h000});
        ref_mem[15'o33333] = 12'o4321;
        clr_counts();
        req = 2'b10;
        run_txn(40);
        check("rst_after_write", mem[15'o33333], ref_mem[15'o33333]);
        check("rst_after_we_clks", we_clks, MEM_LAT);

        // ---- round robin, burst limit and GAP ----
        tag = "rr";
        r_break_ok = 1'b1;
        r_started  = 1'b0;
        r_low      = 0;
        // lone dev1 cycle leaves the pointer on device 1
        exp_q.push_back({2'b10, rr_data(R_A1)});
        r_req = 2'b10;
        n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            rr_step(1'b0);
            n++;
        end
        check("rr_warmup_done", exp_q.size(), 0);
        r_req = 2'b00;
        repeat (3) rr_step(1'b0);
        check("rr_warmup_idle", r_break_req, 1'b0);
        exp_q.push_back({2'b01, rr_data(R_A0)});
        exp_q.push_back({2'b10, rr_data(R_A1)});
        exp_q.push_back({2'b01, rr_data(R_A0)});
        exp_q.push_back({2'b10, rr_data(R_A1)});
        exp_q.push_back({2'b01, rr_data(R_A0)});
        r_started = 1'b0;
        r_low     = 0;
        r_req     = 2'b11;
        n = 0;
        while (exp_q.size() != 0 && n < 80) begin
            rr_step(1'b1);
            n++;
        end
        check("rr_all_acked", exp_q.size(), 0);
        check("rr_gap_low_clks", r_low, 1);
        exp_q.delete();
        r_req = 2'b00;
        repeat (3) rr_step(1'b0);
        check("rr_final_idle", {r_break_req, r_grant}, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog [%s] actual=timeout required=finish", tag);
        $fatal(1, "simulation time limit reached");
    end

endmodule
